// File: rtl/change_dispenser.sv
// Coin-return side of the vending machine: pays an amount out as the fewest coins,
// largest first (100/50/10/5c), one fixed-width eject pulse per coin. Stock tracking: CHANGE_INVENTORY_EN.
module change_dispenser #(
  parameter int AMT_W        = 7,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req,
  input  logic [AMT_W-1:0] Amount,
  input  logic             Refill,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [AMT_W-1:0] Remain,
  output logic             OneDollar_o,
  output logic             FiftyCents_o,
  output logic             TenCents_o,
  output logic             FiveCents_o,
  output logic [3:0]       Empty
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [AMT_W-1:0] V100 = AMT_W'(100);
  localparam logic [AMT_W-1:0] V50  = AMT_W'(50);
  localparam logic [AMT_W-1:0] V10  = AMT_W'(10);
  localparam logic [AMT_W-1:0] V5   = AMT_W'(5);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Coin vectors are one-hot, bit order {100c, 50c, 10c, 5c}, matching Empty.
  state_t           state_q, state_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic [3:0]       coin_q, coin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [3:0]       eject_q, eject_d;

  logic [3:0]       stock_ok;
  logic [3:0]       fits;
  logic [3:0]       pick;
  logic [AMT_W-1:0] coin_val;
  logic             pay_coin;

  always_comb begin
    fits[3] = (remain_q >= V100);
    fits[2] = (remain_q >= V50);
    fits[1] = (remain_q >= V10);
    fits[0] = (remain_q >= V5);
  end

  // Greedy choice: the largest coin that neither overpays nor is out of stock.
  always_comb begin
    pick = 4'b0000;
    if (fits[3] && stock_ok[3])      pick = 4'b1000;
    else if (fits[2] && stock_ok[2]) pick = 4'b0100;
    else if (fits[1] && stock_ok[1]) pick = 4'b0010;
    else if (fits[0] && stock_ok[0]) pick = 4'b0001;
  end

  always_comb begin
    coin_val = '0;
    case (coin_q)
      4'b1000: coin_val = V100;
      4'b0100: coin_val = V50;
      4'b0010: coin_val = V10;
      4'b0001: coin_val = V5;
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    coin_d   = coin_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    eject_d  = 4'b0000;
    pay_coin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          remain_d = Amount;
          if ((Amount % V5) == '0) begin
            err_d   = 1'b0;
            state_d = S_SELECT;
          end else begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_SELECT: begin
        if (remain_q == '0) begin
          err_d   = 1'b0;
          state_d = S_FINISH;
        end else if (pick == 4'b0000) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          coin_d  = pick;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          eject_d = pick;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        // The coin counts as paid only once its pulse has completed.
        if (cnt_q == '0) begin
          remain_d = remain_q - coin_val;
          pay_coin = 1'b1;
          cnt_d    = CNT_W'(GAP_CYCLES - 1);
          state_d  = S_GAP;
        end else begin
          eject_d = coin_q;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_SELECT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      coin_q   <= 4'b0000;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      eject_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      coin_q   <= coin_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      eject_q  <= eject_d;
    end
  end

`ifdef CHANGE_INVENTORY_EN
  logic [STOCK_W-1:0] stock_q [4];

  // Refill only lands while idle; a same-edge Req still sees the reloaded stock in SELECT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else if (Refill && (state_q == S_IDLE)) begin
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else if (pay_coin) begin
      for (int i = 0; i < 4; i++) begin
        if (coin_q[i]) stock_q[i] <= stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) stock_ok[i] = (stock_q[i] != '0);
  end

  assign Empty = ~stock_ok;
`else
  logic unused_refill;
  logic unused_pay_coin;
  assign unused_refill   = Refill;
  assign unused_pay_coin = pay_coin;
  assign stock_ok        = 4'b1111;
  assign Empty           = 4'b0000;
`endif

  assign Ready        = (state_q == S_IDLE);
  assign Busy         = ~Ready;
  assign Done         = (state_q == S_FINISH);
  assign Err          = Done & err_q;
  assign Remain       = remain_q;
  assign OneDollar_o  = eject_q[3];
  assign FiftyCents_o = eject_q[2];
  assign TenCents_o   = eject_q[1];
  assign FiveCents_o  = eject_q[0];

endmodule
